// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between the fetch and data ports,
// with a starvation guard for fetch and a sticky timeout error.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic              err
);

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned TMO_W    = 8;
    localparam logic [DATA_W-1:0] TMO_DATA = {(DATA_W/4){4'hD}};

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                mem_req_d, mem_we_d, if_ready_d, d_ready_d, err_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d, if_rdata_d, d_rdata_d;
    logic                grant_f, grant_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            tmo_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ready  <= if_ready_d;
            d_ready   <= d_ready_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            err       <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        err_d       = err;
        grant_f     = 1'b0;
        grant_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // The ready cycle still sees the completed request, so no grant then
                if (!if_ready && !d_ready) begin
                    grant_f = if_req && (!d_req || starve_q == STARVE_W'(STARVE_MAX));
                    grant_d = d_req && !grant_f;
                end
                if (grant_f) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    tmo_d       = '0;
                    starve_d    = '0;
                end else if (grant_d) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    tmo_d       = '0;
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            FETCH, DATA: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == FETCH) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Abandon the access and complete it with the poison pattern
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == FETCH) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = TMO_DATA;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = TMO_DATA;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign stall_f = if_req & ~if_ready;
    assign stall_m = d_req & ~d_ready;

endmodule
